// File: rtl/ram_sync_read_be.sv
// Synchronous-read RAM with per-byte write enables, configurable read latency,
// selectable same-address collision behaviour and optional zero-fill after reset.
module ram_sync_read_be #(
    parameter int unsigned AWIDTH         = 3,
    parameter int unsigned DWIDTH         = 32,
    parameter int unsigned RD_LATENCY     = 1,
    parameter int unsigned WR_MODE        = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic                  ready,
    input  logic                  wr_en,
    input  logic [AWIDTH-1:0]     wr_addr,
    input  logic [DWIDTH/8-1:0]   wr_be,
    input  logic [DWIDTH-1:0]     wr_data,
    input  logic                  rd_en,
    input  logic [AWIDTH-1:0]     rd_addr,
    output logic [DWIDTH-1:0]     rd_data,
    output logic                  rd_valid
);

    localparam int unsigned DEPTH  = 2 ** AWIDTH;
    localparam int unsigned NBYTES = DWIDTH / 8;

    // Elaboration-time parameter sanity checks.
    if ((DWIDTH % 8) != 0 || DWIDTH == 0) begin : g_bad_dwidth
        $error("ram_sync_read_be: DWIDTH must be a non-zero multiple of 8");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("ram_sync_read_be: RD_LATENCY must be 1 or 2");
    end
    if (WR_MODE > 1) begin : g_bad_wr_mode
        $error("ram_sync_read_be: WR_MODE must be 0 or 1");
    end

    typedef enum logic [0:0] {
        StClear,
        StRun
    } state_e;

    // Without zero-fill the FSM comes out of reset already in RUN; ready still
    // waits for the first edge because it is a separate register cleared by reset.
    localparam state_e RstState = (CLEAR_ON_RESET != 0) ? StClear : StRun;

    state_e              state_q, state_d;
    logic                ready_q, ready_d;
    logic [AWIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic                clr_we;

    logic [DWIDTH-1:0]   mem_q [DEPTH];

    logic                wr_fire;
    logic                rd_fire;
    logic [DWIDTH-1:0]   wr_old;
    logic [DWIDTH-1:0]   wr_merged;
    logic [DWIDTH-1:0]   rd_word;

    logic                rd_valid1_q;
    logic [DWIDTH-1:0]   rd_data1_q;

    // Requests are only honoured once the block reports ready.
    assign wr_fire = wr_en & ready_q;
    assign rd_fire = rd_en & ready_q;
    assign ready   = ready_q;

    // Next-state logic: walk the clear counter across the array, then run.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        unique case (state_q)
            StClear: begin
                clr_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + AWIDTH'(1);
                if (clr_cnt_q == AWIDTH'(DEPTH - 1)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                state_d = StRun;
            end
            default: begin
                state_d = RstState;
            end
        endcase
        ready_d = (state_d == StRun);
    end

    // FSM state, clear counter and ready flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RstState;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= ready_d;
        end
    end

    // Byte-enable merge of the write data onto the currently stored word.
    always_comb begin
        wr_old    = mem_q[wr_addr];
        wr_merged = wr_old;
        for (int b = 0; b < int'(NBYTES); b++) begin
            if (wr_be[b]) begin
                wr_merged[8*b +: 8] = wr_data[8*b +: 8];
            end
        end
    end

    // Read word selection; write-first forwards the merged word on a same-address hit.
    always_comb begin
        rd_word = mem_q[rd_addr];
        if (WR_MODE != 0 && wr_fire && (wr_addr == rd_addr)) begin
            rd_word = wr_merged;
        end
    end

    // Storage array: zero-fill while clearing, otherwise byte-masked writes.
    always_ff @(posedge clock) begin
        if (clr_we) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (wr_fire) begin
            mem_q[wr_addr] <= wr_merged;
        end
    end

    // First read stage: capture the addressed word, hold data between responses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid1_q <= 1'b0;
            rd_data1_q  <= '0;
        end else begin
            rd_valid1_q <= rd_fire;
            if (rd_fire) begin
                rd_data1_q <= rd_word;
            end
        end
    end

    if (RD_LATENCY >= 2) begin : g_lat2
        logic                rd_valid2_q;
        logic [DWIDTH-1:0]   rd_data2_q;

        // Extra output stage; data only advances with a valid response.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                rd_valid2_q <= 1'b0;
                rd_data2_q  <= '0;
            end else begin
                rd_valid2_q <= rd_valid1_q;
                if (rd_valid1_q) begin
                    rd_data2_q <= rd_data1_q;
                end
            end
        end

        assign rd_valid = rd_valid2_q;
        assign rd_data  = rd_data2_q;
    end else begin : g_lat1
        assign rd_valid = rd_valid1_q;
        assign rd_data  = rd_data1_q;
    end

endmodule
